// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: CP0 register bank and interrupt/exception sequencer.
//   Holds Status(12), Cause(13) and EPC(14). It synchronises and masks the
//   hardware interrupt lines and picks between exception, ERET and interrupt.
//   The chosen event produces a registered one-cycle redirect to fetch.
//   Optional timer: define CP0_TIMER_EN to add Count(9) and Compare(11).
//   The timer's pending flag is OR'ed into Cause.IP[7].
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   irq_in[NUM_IRQ]          asynchronous level interrupts -> Cause.IP[2+i]
//   stall                    no request accepted while high
//   exc_req/exc_code/exc_pc/exc_bd   exception from execute stage
//   resume_pc/resume_bd      EPC/BD source for interrupts
//   eret                     return from exception
//   mtc0/c0_addr/c0_wdata    CP0 write port; c0_rdata is combinational read
//   redirect/redirect_pc     one-cycle flush + new PC
//   intr_ack                 pulse with redirect when an interrupt is taken
//   status_out/cause_out/epc_out     current register values
//
// state | meaning
// RUN   | normal operation, requests and mtc0 accepted
// REDIR | redirect pulse cycle; requests and mtc0 belong to flushed instrs
module cp0_intr_ctrl #(
  parameter int          NUM_IRQ   = 6,
  parameter logic [31:0] VECTOR_PC = 32'h0000_0008
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               stall,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic               exc_bd,
  input  logic [31:0]        resume_pc,
  input  logic               resume_bd,
  input  logic               eret,
  input  logic               mtc0,
  input  logic [4:0]         c0_addr,
  input  logic [31:0]        c0_wdata,
  output logic [31:0]        c0_rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               intr_ack,
  output logic [31:0]        status_out,
  output logic [31:0]        cause_out,
  output logic [31:0]        epc_out
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t state, state_nxt;

  logic [7:0]         im;
  logic               exl, ie;
  logic               bd;
  logic [1:0]         ip_sw;
  logic [4:0]         exc_code_q;
  logic [31:0]        epc;
  logic [NUM_IRQ-1:0] sync1, sync2;
  logic [5:0]         ip_hw;
  logic [7:0]         ip;
  logic               pend;
  logic               take_exc, take_eret, take_intr, wr_en;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        phase, timer_pend;
`endif

  always_comb begin
    ip_hw = '0;
    ip_hw[NUM_IRQ-1:0] = sync2;
`ifdef CP0_TIMER_EN
    ip_hw[5] = ip_hw[5] | timer_pend;
`endif
  end

  assign ip   = {ip_hw, ip_sw};
  assign pend = ie & ~exl & (|(ip & im));

  always_comb begin
    state_nxt = state;
    take_exc  = 1'b0;
    take_eret = 1'b0;
    take_intr = 1'b0;
    wr_en     = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          if (exc_req)   take_exc  = 1'b1;
          else if (eret) take_eret = 1'b1;
          else if (pend) take_intr = 1'b1;
        end
        // An accepted event flushes the instruction carrying the mtc0.
        if (take_exc || take_eret || take_intr) state_nxt = REDIR;
        else                                    wr_en     = mtc0;
      end
      REDIR: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im          <= '0;
      exl         <= 1'b0;
      ie          <= 1'b0;
      bd          <= 1'b0;
      ip_sw       <= '0;
      exc_code_q  <= '0;
      epc         <= '0;
      sync1       <= '0;
      sync2       <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      intr_ack    <= 1'b0;
    end else begin
      sync1    <= irq_in;
      sync2    <= sync1;
      redirect <= take_exc | take_eret | take_intr;
      intr_ack <= take_intr;
      if (take_exc) begin
        exl         <= 1'b1;
        epc         <= exc_pc;
        bd          <= exc_bd;
        exc_code_q  <= exc_code;
        redirect_pc <= VECTOR_PC;
      end else if (take_eret) begin
        exl         <= 1'b0;
        redirect_pc <= epc;
      end else if (take_intr) begin
        exl         <= 1'b1;
        epc         <= resume_pc;
        bd          <= resume_bd;
        exc_code_q  <= '0;
        redirect_pc <= VECTOR_PC;
      end else if (wr_en) begin
        case (c0_addr)
          5'd12: begin
            im  <= c0_wdata[15:8];
            exl <= c0_wdata[1];
            ie  <= c0_wdata[0];
          end
          5'd13:   ip_sw <= c0_wdata[9:8];
          5'd14:   epc   <= c0_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  // Count advances on every second clock; a Count write restarts that phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      compare    <= '0;
      phase      <= 1'b0;
      timer_pend <= 1'b0;
    end else begin
      if (wr_en && c0_addr == 5'd9) begin
        count <= c0_wdata;
        phase <= 1'b0;
      end else begin
        phase <= ~phase;
        if (phase) count <= count + 32'd1;
      end
      if (wr_en && c0_addr == 5'd11) begin
        compare    <= c0_wdata;
        timer_pend <= 1'b0;
      end else if (phase && !(wr_en && c0_addr == 5'd9) && (count + 32'd1 == compare)) begin
        timer_pend <= 1'b1;
      end
    end
  end
`endif

  assign status_out = {16'h0, im, 6'h0, exl, ie};
  assign cause_out  = {bd, 15'h0, ip, 1'b0, exc_code_q, 2'b00};
  assign epc_out    = epc;

  always_comb begin
    c0_rdata = '0;
    case (c0_addr)
      5'd12: c0_rdata = status_out;
      5'd13: c0_rdata = cause_out;
      5'd14: c0_rdata = epc;
`ifdef CP0_TIMER_EN
      5'd9:  c0_rdata = count;
      5'd11: c0_rdata = compare;
`endif
      default: c0_rdata = '0;
    endcase
  end

endmodule
